// File: rtl/tile_map_pkg.sv
// Shared widths, pipeline owner tags and address packing for the tile map arbiter.
package tile_map_pkg;

  localparam int MAP_X_W    = 6;
  localparam int MAP_Y_W    = 5;
  localparam int MAP_ADDR_W = 11;

  // Owner of a RAM slot; travels down the G/I/D pipeline with the access.
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    DISP    = 2'd1,
    GAME_RD = 2'd2,
    GAME_WR = 2'd3
  } owner_e;

  function automatic logic [MAP_ADDR_W-1:0] pack_addr(input logic [MAP_Y_W-1:0] y,
                                                      input logic [MAP_X_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/map_fetch_detect.sv
// Remembers the last display coordinate sent to the RAM and flags when a new fetch is needed.
module map_fetch_detect
  import tile_map_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               display_en,
  input  logic [MAP_X_W-1:0] xmap,
  input  logic [MAP_Y_W-1:0] ymap,
  input  logic               grant_disp,
  output logic               disp_demand,
  output logic               coord_match
);

  logic [MAP_X_W-1:0] last_x;
  logic [MAP_Y_W-1:0] last_y;
  logic               last_vld;

  // Leaving active video forgets the coordinate so re-entry always refetches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_x   <= '0;
      last_y   <= '0;
      last_vld <= 1'b0;
    end else if (!display_en) begin
      last_vld <= 1'b0;
    end else if (grant_disp) begin
      last_x   <= xmap;
      last_y   <= ymap;
      last_vld <= 1'b1;
    end
  end

  assign coord_match = last_vld && (xmap == last_x) && (ymap == last_y);
  assign disp_demand = display_en && !coord_match;

endmodule

// File: rtl/tile_map_arbiter.sv
// Shares the single-port tile map RAM between display fetches and game REQ/ACK accesses.
// Define MAP_BLANK_ONLY_EN to restrict game writes to blanking (DISPLAY_EN low).
module tile_map_arbiter
  import tile_map_pkg::*;
#(
  parameter int TILE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  display_en,
  input  logic [MAP_X_W-1:0]    xmap,
  input  logic [MAP_Y_W-1:0]    ymap,
  output logic [TILE_W-1:0]     tile_out,
  output logic                  tile_valid,
  input  logic                  game_req,
  input  logic                  game_we,
  input  logic [MAP_X_W-1:0]    game_x,
  input  logic [MAP_Y_W-1:0]    game_y,
  input  logic [TILE_W-1:0]     game_wdata,
  output logic                  game_ack,
  output logic [TILE_W-1:0]     game_rdata,
  output logic [MAP_ADDR_W-1:0] ram_addr,
  output logic                  ram_we,
  output logic [TILE_W-1:0]     ram_wdata,
  input  logic [TILE_W-1:0]     ram_rdata
);

  logic                  disp_demand;
  logic                  coord_match;
  logic                  game_busy;
  logic                  game_write_ok;
  logic                  game_demand;
  logic                  ack_next;
  logic                  disp_in_flight;
  owner_e                grant;
  logic [MAP_ADDR_W-1:0] grant_addr;

  owner_e                g_owner;
  logic [MAP_ADDR_W-1:0] g_addr;
  logic [TILE_W-1:0]     g_wdata;
  owner_e                i_owner;
  owner_e                d_owner;

  map_fetch_detect u_detect (
    .clk         (clk),
    .reset_n     (reset_n),
    .display_en  (display_en),
    .xmap        (xmap),
    .ymap        (ymap),
    .grant_disp  (grant == DISP),
    .disp_demand (disp_demand),
    .coord_match (coord_match)
  );

`ifdef MAP_BLANK_ONLY_EN
  assign game_write_ok = !display_en;
`else
  assign game_write_ok = 1'b1;
`endif

  assign game_demand    = game_req && !game_busy && (!game_we || game_write_ok);
  assign ack_next       = (i_owner == GAME_WR) || (d_owner == GAME_RD);
  assign disp_in_flight = (g_owner == DISP) || (i_owner == DISP);

  // Fixed priority: display takes the slot whenever it wants one.
  always_comb begin
    grant      = NONE;
    grant_addr = pack_addr(ymap, xmap);
    if (disp_demand) begin
      grant = DISP;
    end else if (game_demand) begin
      grant      = game_we ? GAME_WR : GAME_RD;
      grant_addr = pack_addr(game_y, game_x);
    end
  end

  // Grant, issue, data and result stages; write ACK comes out of D, read results out of R.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_owner    <= NONE;
      g_addr     <= '0;
      g_wdata    <= '0;
      i_owner    <= NONE;
      d_owner    <= NONE;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      game_ack   <= 1'b0;
      game_rdata <= '0;
      game_busy  <= 1'b0;
      tile_out   <= '0;
      tile_valid <= 1'b0;
    end else begin
      g_owner <= grant;
      if (grant != NONE) begin
        g_addr  <= grant_addr;
        g_wdata <= game_wdata;
      end

      i_owner <= g_owner;
      ram_we  <= (g_owner == GAME_WR);
      if (g_owner != NONE) ram_addr <= g_addr;
      if (g_owner == GAME_WR) ram_wdata <= g_wdata;

      d_owner  <= i_owner;
      game_ack <= ack_next;
      if (d_owner == GAME_RD) game_rdata <= ram_rdata;
      if (d_owner == DISP) tile_out <= ram_rdata;

      if (grant == GAME_RD || grant == GAME_WR) game_busy <= 1'b1;
      else if (ack_next) game_busy <= 1'b0;

      // Valid only once the newest display fetch has landed and the coordinate still matches it.
      tile_valid <= ((d_owner == DISP) || tile_valid) && display_en && coord_match
                    && !disp_in_flight;
    end
  end

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Directed self-checking bench for tile_map_arbiter with a synchronous-read RAM model.
module tb_tile_map_arbiter;

  logic        clk;
  logic        reset_n;
  logic        display_en;
  logic [5:0]  xmap;
  logic [4:0]  ymap;
  logic [3:0]  tile_out;
  logic        tile_valid;
  logic        game_req;
  logic        game_we;
  logic [5:0]  game_x;
  logic [4:0]  game_y;
  logic [3:0]  game_wdata;
  logic        game_ack;
  logic [3:0]  game_rdata;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata;

  logic [3:0]  mem [2048];
  logic        mem_init;
  int          checks;
  int          errors;

  tile_map_arbiter #(.TILE_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .display_en (display_en),
    .xmap       (xmap),
    .ymap       (ymap),
    .tile_out   (tile_out),
    .tile_valid (tile_valid),
    .game_req   (game_req),
    .game_we    (game_we),
    .game_x     (game_x),
    .game_y     (game_y),
    .game_wdata (game_wdata),
    .game_ack   (game_ack),
    .game_rdata (game_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] init_val(input int i);
    int t;
    t = i * 7 + 3;
    return t[3:0];
  endfunction

  // Single-port RAM, read-first, one cycle read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
      ram_rdata <= 4'h0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_game(input logic we, input logic [5:0] x, input logic [4:0] y,
                          input logic [3:0] wd, input int ncyc,
                          output int ack_k, output int ack_cnt, output int we_cnt,
                          output logic [3:0] rd, output logic [10:0] we_addr,
                          output logic [3:0] we_data);
    game_we    = we;
    game_x     = x;
    game_y     = y;
    game_wdata = wd;
    game_req   = 1'b1;
    ack_k = -1; ack_cnt = 0; we_cnt = 0; rd = 4'h0; we_addr = '0; we_data = 4'h0;
    for (int k = 0; k < ncyc; k++) begin
      step();
      if (ram_we) begin
        we_cnt++;
        we_addr = ram_addr;
        we_data = ram_wdata;
      end
      if (game_ack) begin
        ack_cnt++;
        if (ack_k < 0) begin
          ack_k = k;
          rd = game_rdata;
        end
        game_req = 1'b0;
      end
    end
    game_req = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (tile_out !== 4'h0) begin errors++; $display("[TB] FAIL reset tile_out: got %h want 0", tile_out); end
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset tile_valid: got %b want 0", tile_valid); end
    checks++; if (game_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset game_ack: got %b want 0", game_ack); end
    checks++; if (game_rdata !== 4'h0) begin errors++; $display("[TB] FAIL reset game_rdata: got %h want 0", game_rdata); end
    checks++; if (ram_addr !== 11'h0) begin errors++; $display("[TB] FAIL reset ram_addr: got %h want 0", ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset ram_we: got %b want 0", ram_we); end
    checks++; if (ram_wdata !== 4'h0) begin errors++; $display("[TB] FAIL reset ram_wdata: got %h want 0", ram_wdata); end
  endtask

  task automatic test_write_read();
    int ak, ac, wc;
    logic [3:0] rd, wdat;
    logic [10:0] wa;
    display_en = 1'b0;
    step(); step();
    run_game(1'b1, 6'd5, 5'd3, 4'hA, 6, ak, ac, wc, rd, wa, wdat);
    checks++; if (ak !== 2) begin errors++; $display("[TB] FAIL write ack_cycle: got %0d want 2", ak); end
    checks++; if (wc !== 1) begin errors++; $display("[TB] FAIL write ram_we_pulses: got %0d want 1", wc); end
    checks++; if (wa !== 11'h0C5) begin errors++; $display("[TB] FAIL write ram_addr: got %h want 0c5", wa); end
    checks++; if (wdat !== 4'hA) begin errors++; $display("[TB] FAIL write ram_wdata: got %h want a", wdat); end
    run_game(1'b0, 6'd5, 5'd3, 4'h0, 6, ak, ac, wc, rd, wa, wdat);
    checks++; if (ak !== 3) begin errors++; $display("[TB] FAIL read ack_cycle: got %0d want 3", ak); end
    checks++; if (rd !== 4'hA) begin errors++; $display("[TB] FAIL read game_rdata: got %h want a", rd); end
    checks++; if (wc !== 0) begin errors++; $display("[TB] FAIL read ram_we_pulses: got %0d want 0", wc); end
  endtask

  task automatic test_reset_mid_read();
    int ak, ac, wc, acks;
    logic [3:0] rd, wdat;
    logic [10:0] wa;
    game_we = 1'b0; game_x = 6'd5; game_y = 5'd3; game_req = 1'b1;
    step(); step();
    reset_n  = 1'b0;
    game_req = 1'b0;
    #1;
    test_reset();
    step(); step();
    reset_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (game_ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("[TB] FAIL midreset stray_acks: got %0d want 0", acks); end
    run_game(1'b0, 6'd5, 5'd3, 4'h0, 6, ak, ac, wc, rd, wa, wdat);
    checks++; if (ak !== 3) begin errors++; $display("[TB] FAIL midreset next_ack_cycle: got %0d want 3", ak); end
    checks++; if (rd !== 4'hA) begin errors++; $display("[TB] FAIL midreset next_rdata: got %h want a", rd); end
  endtask

  task automatic test_display_fetch();
    logic [10:0] prev;
    int changes, low;
    ymap = 5'd2; xmap = 6'd0; display_en = 1'b1;
    repeat (6) step();
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("[TB] FAIL disp initial_valid: got %b want 1", tile_valid); end
    checks++; if (tile_out !== init_val(128)) begin errors++; $display("[TB] FAIL disp initial_tile: got %h want %h", tile_out, init_val(128)); end
    for (int s = 1; s <= 3; s++) begin
      xmap = s[5:0];
      prev = ram_addr; changes = 0; low = 0;
      for (int k = 0; k < 32; k++) begin
        step();
        if (ram_addr !== prev) changes++;
        prev = ram_addr;
        if (!tile_valid) low++;
      end
      checks++; if (changes !== 1) begin errors++; $display("[TB] FAIL disp step%0d ram_reads: got %0d want 1", s, changes); end
      checks++; if (low !== 3) begin errors++; $display("[TB] FAIL disp step%0d valid_low: got %0d want 3", s, low); end
      checks++; if (ram_addr !== 11'(128 + s)) begin errors++; $display("[TB] FAIL disp step%0d ram_addr: got %h want %h", s, ram_addr, 11'(128 + s)); end
      checks++; if (tile_out !== init_val(128 + s)) begin errors++; $display("[TB] FAIL disp step%0d tile_out: got %h want %h", s, tile_out, init_val(128 + s)); end
    end
  endtask

  task automatic test_collision();
    logic [10:0] addr1, addr2;
    logic [3:0] rd;
    int ak;
    addr1 = '0; addr2 = '0; rd = 4'h0; ak = -1;
    xmap = 6'd4;
    game_we = 1'b0; game_x = 6'd5; game_y = 5'd3; game_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 1) addr1 = ram_addr;
      if (k == 2) addr2 = ram_addr;
      if (game_ack && ak < 0) begin
        ak = k;
        rd = game_rdata;
        game_req = 1'b0;
      end
    end
    game_req = 1'b0;
    checks++; if (addr1 !== 11'd132) begin errors++; $display("[TB] FAIL collide first_issue: got %h want 084", addr1); end
    checks++; if (addr2 !== 11'h0C5) begin errors++; $display("[TB] FAIL collide second_issue: got %h want 0c5", addr2); end
    checks++; if (ak !== 4) begin errors++; $display("[TB] FAIL collide ack_cycle: got %0d want 4", ak); end
    checks++; if (rd !== 4'hA) begin errors++; $display("[TB] FAIL collide rdata: got %h want a", rd); end
  endtask

  task automatic test_back_to_back();
    int acks [4];
    int n, wc;
    display_en = 1'b0;
    step();
    n = 0; wc = 0;
    for (int i = 0; i < 4; i++) acks[i] = -1;
    game_we = 1'b1; game_x = 6'd0; game_y = 5'd10; game_wdata = 4'd1; game_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ram_we) wc++;
      if (game_ack) begin
        if (n < 4) acks[n] = k;
        n++;
        if (n < 4) begin
          game_x     = n[5:0];
          game_wdata = 4'(n + 1);
        end else begin
          game_req = 1'b0;
        end
      end
    end
    game_req = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL b2b ack_count: got %0d want 4", n); end
    checks++; if (wc !== 4) begin errors++; $display("[TB] FAIL b2b ram_we_pulses: got %0d want 4", wc); end
    checks++; if (acks[0] !== 2) begin errors++; $display("[TB] FAIL b2b first_ack: got %0d want 2", acks[0]); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acks[i] - acks[i-1] !== 3) begin
        errors++; $display("[TB] FAIL b2b ack_spacing%0d: got %0d want 3", i, acks[i] - acks[i-1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[640 + i] !== 4'(i + 1)) begin
        errors++; $display("[TB] FAIL b2b ram_contents%0d: got %h want %h", i, mem[640 + i], 4'(i + 1));
      end
    end
  endtask

  task automatic test_active_video();
    int ak, ac, wc;
    logic [3:0] rd, wdat;
    logic [10:0] wa;
    display_en = 1'b1;
    repeat (6) step();
`ifdef MAP_BLANK_ONLY_EN
    wc = 0; ac = 0; ak = -1;
    game_we = 1'b1; game_x = 6'd7; game_y = 5'd1; game_wdata = 4'h6; game_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ram_we) wc++;
      if (game_ack) ac++;
    end
    checks++; if (wc !== 0) begin errors++; $display("[TB] FAIL blank held_write_we: got %0d want 0", wc); end
    checks++; if (ac !== 0) begin errors++; $display("[TB] FAIL blank held_write_ack: got %0d want 0", ac); end
    display_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (game_ack && ak < 0) begin
        ak = k;
        game_req = 1'b0;
      end
    end
    game_req = 1'b0;
    checks++; if (ak !== 2) begin errors++; $display("[TB] FAIL blank write_ack_cycle: got %0d want 2", ak); end
    display_en = 1'b1;
    repeat (6) step();
`else
    run_game(1'b1, 6'd7, 5'd1, 4'h6, 6, ak, ac, wc, rd, wa, wdat);
    checks++; if (ak !== 2) begin errors++; $display("[TB] FAIL active write_ack_cycle: got %0d want 2", ak); end
    checks++; if (wc !== 1) begin errors++; $display("[TB] FAIL active write_we_pulses: got %0d want 1", wc); end
`endif
    run_game(1'b0, 6'd7, 5'd1, 4'h0, 6, ak, ac, wc, rd, wa, wdat);
    checks++; if (ak !== 3) begin errors++; $display("[TB] FAIL active read_ack_cycle: got %0d want 3", ak); end
    checks++; if (rd !== 4'h6) begin errors++; $display("[TB] FAIL active read_rdata: got %h want 6", rd); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; mem_init = 1'b1;
    display_en = 1'b0; xmap = '0; ymap = '0;
    game_req = 1'b0; game_we = 1'b0; game_x = '0; game_y = '0; game_wdata = '0;
    step(); step();
    mem_init = 1'b0;
    test_reset();
    reset_n = 1'b1;
    step();
    test_write_read();
    test_reset_mid_read();
    test_display_fetch();
    test_collision();
    test_back_to_back();
    test_active_video();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
